// File: rtl/apb_master_bridge.sv
// Single-outstanding APB initiator: turns a valid/ready request into one
// SETUP/ACCESS transfer and returns a held response, aborting hung slaves.
module apb_master_bridge #(
  parameter int APB_ADDR_WIDTH = 12,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      req_valid_i,
  output logic                      req_ready_o,
  input  logic [APB_ADDR_WIDTH-1:0] req_addr_i,
  input  logic                      req_we_i,
  input  logic [31:0]               req_wdata_i,
  output logic                      rsp_valid_o,
  input  logic                      rsp_ready_i,
  output logic [31:0]               rsp_rdata_o,
  output logic                      rsp_err_o,
  output logic                      timeout_o,
  output logic [APB_ADDR_WIDTH-1:0] PADDR,
  output logic [31:0]               PWDATA,
  output logic                      PWRITE,
  output logic                      PSEL,
  output logic                      PENABLE,
  input  logic [31:0]               PRDATA,
  input  logic                      PREADY,
  input  logic                      PSLVERR
);

  localparam bit TIMEOUT_EN = (TIMEOUT_CYCLES != 0);
  localparam int CNT_W      = TIMEOUT_EN ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = TIMEOUT_EN ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETUP,
    ST_ACCESS,
    ST_RESP
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] wait_cnt;

  // req_ready_o mirrors the IDLE state, so it comes out of reset high.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state       <= ST_IDLE;
      wait_cnt    <= '0;
      req_ready_o <= 1'b1;
      rsp_valid_o <= 1'b0;
      rsp_rdata_o <= '0;
      rsp_err_o   <= 1'b0;
      timeout_o   <= 1'b0;
      PADDR       <= '0;
      PWDATA      <= '0;
      PWRITE      <= 1'b0;
      PSEL        <= 1'b0;
      PENABLE     <= 1'b0;
    end else begin
      timeout_o <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (req_valid_i) begin
            PADDR       <= req_addr_i;
            PWRITE      <= req_we_i;
            PWDATA      <= req_wdata_i;
            wait_cnt    <= '0;
            req_ready_o <= 1'b0;
            PSEL        <= 1'b1;
            state       <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          PENABLE <= 1'b1;
          state   <= ST_ACCESS;
        end
        ST_ACCESS: begin
          // A completing slave wins over an abort landing in the same cycle.
          if (PREADY) begin
            rsp_rdata_o <= PWRITE ? 32'h0 : PRDATA;
            rsp_err_o   <= PSLVERR;
            rsp_valid_o <= 1'b1;
            PSEL        <= 1'b0;
            PENABLE     <= 1'b0;
            state       <= ST_RESP;
          end else if (TIMEOUT_EN && (wait_cnt == CNT_LAST)) begin
            rsp_rdata_o <= 32'h0;
            rsp_err_o   <= 1'b1;
            rsp_valid_o <= 1'b1;
            timeout_o   <= 1'b1;
            PSEL        <= 1'b0;
            PENABLE     <= 1'b0;
            state       <= ST_RESP;
          end else if (TIMEOUT_EN) begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        ST_RESP: begin
          if (rsp_ready_i) begin
            rsp_valid_o <= 1'b0;
            req_ready_o <= 1'b1;
            state       <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_master_bridge.sv
// Randomized bench for apb_master_bridge: a behavioural slave plus a
// transfer-level model predicting response, error, timeout and ACCESS length.
module tb_apb_master_bridge;

  localparam int AW = 12;
  localparam int T  = 4;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic          req_valid_i;
  logic          req_ready_o;
  logic [AW-1:0] req_addr_i;
  logic          req_we_i;
  logic [31:0]   req_wdata_i;
  logic          rsp_valid_o;
  logic          rsp_ready_i;
  logic [31:0]   rsp_rdata_o;
  logic          rsp_err_o;
  logic          timeout_o;
  logic [AW-1:0] PADDR;
  logic [31:0]   PWDATA;
  logic          PWRITE;
  logic          PSEL;
  logic          PENABLE;
  logic [31:0]   PRDATA;
  logic          PREADY;
  logic          PSLVERR;

  int errors = 0;
  int checks = 0;

  int          slv_wait  = 0;
  logic        slv_err   = 1'b0;
  logic [31:0] slv_rdata = '0;
  int          acc_k     = 0;

  apb_master_bridge #(
    .APB_ADDR_WIDTH(AW),
    .TIMEOUT_CYCLES(T)
  ) dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .req_valid_i(req_valid_i),
    .req_ready_o(req_ready_o),
    .req_addr_i (req_addr_i),
    .req_we_i   (req_we_i),
    .req_wdata_i(req_wdata_i),
    .rsp_valid_o(rsp_valid_o),
    .rsp_ready_i(rsp_ready_i),
    .rsp_rdata_o(rsp_rdata_o),
    .rsp_err_o  (rsp_err_o),
    .timeout_o  (timeout_o),
    .PADDR      (PADDR),
    .PWDATA     (PWDATA),
    .PWRITE     (PWRITE),
    .PSEL       (PSEL),
    .PENABLE    (PENABLE),
    .PRDATA     (PRDATA),
    .PREADY     (PREADY),
    .PSLVERR    (PSLVERR)
  );

  always #5 clk_i = ~clk_i;

  // Slave: PREADY rises on ACCESS cycle number slv_wait; garbage everywhere else.
  always @(negedge clk_i) begin
    if (PSEL && PENABLE) begin
      PREADY  = (acc_k == slv_wait);
      PSLVERR = PREADY ? slv_err : 1'($urandom_range(0, 1));
      PRDATA  = PREADY ? slv_rdata : $urandom;
      acc_k++;
    end else begin
      acc_k   = 0;
      PREADY  = 1'($urandom_range(0, 1));
      PSLVERR = 1'($urandom_range(0, 1));
      PRDATA  = $urandom;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  // Transfer-level outcome from the wait count the slave will insert.
  function automatic void refModel(input logic we, input int w, input logic err,
                                   input logic [31:0] prd, output logic [31:0] e_rdata,
                                   output logic e_err, output logic e_to, output int e_acc);
    if (T != 0 && w >= T) begin
      e_acc   = T;
      e_rdata = 32'h0;
      e_err   = 1'b1;
      e_to    = 1'b1;
    end else begin
      e_acc   = w + 1;
      e_rdata = we ? 32'h0 : prd;
      e_err   = err;
      e_to    = 1'b0;
    end
  endfunction

  // Called at a negedge with the DUT idle; returns at the negedge after the response is taken.
  task automatic applyStimulus(input logic [AW-1:0] addr, input logic we, input logic [31:0] wdata,
                               input int w, input logic err, input logic [31:0] prd, input int hold);
    logic [31:0] e_rdata;
    logic        e_err;
    logic        e_to;
    int          e_acc;
    int          acc;
    refModel(we, w, err, prd, e_rdata, e_err, e_to, e_acc);
    slv_wait  = w;
    slv_err   = err;
    slv_rdata = prd;
    checkOutput("req_ready_idle", 32'(req_ready_o), 32'd1);
    req_valid_i = 1'b1;
    req_addr_i  = addr;
    req_we_i    = we;
    req_wdata_i = wdata;
    @(posedge clk_i);
    #1;
    req_addr_i  = AW'($urandom);
    req_we_i    = 1'($urandom_range(0, 1));
    req_wdata_i = $urandom;
    @(negedge clk_i);
    checkOutput("setup_psel", 32'(PSEL), 32'd1);
    checkOutput("setup_penable", 32'(PENABLE), 32'd0);
    checkOutput("setup_paddr", 32'(PADDR), 32'(addr));
    checkOutput("setup_pwrite", 32'(PWRITE), 32'(we));
    checkOutput("setup_pwdata", PWDATA, wdata);
    checkOutput("setup_req_ready", 32'(req_ready_o), 32'd0);
    acc = 0;
    @(negedge clk_i);
    while (PSEL && PENABLE && acc < 20) begin
      acc++;
      checkOutput("access_paddr", 32'(PADDR), 32'(addr));
      checkOutput("access_pwdata", PWDATA, wdata);
      checkOutput("access_pwrite", 32'(PWRITE), 32'(we));
      checkOutput("access_timeout_low", 32'(timeout_o), 32'd0);
      @(negedge clk_i);
    end
    req_valid_i = 1'b0;
    checkOutput("access_cycles", 32'(acc), 32'(e_acc));
    checkOutput("rsp_valid", 32'(rsp_valid_o), 32'd1);
    checkOutput("rsp_rdata", rsp_rdata_o, e_rdata);
    checkOutput("rsp_err", 32'(rsp_err_o), 32'(e_err));
    checkOutput("timeout_pulse", 32'(timeout_o), 32'(e_to));
    checkOutput("resp_psel", 32'(PSEL), 32'd0);
    checkOutput("resp_req_ready", 32'(req_ready_o), 32'd0);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk_i);
      checkOutput("hold_rsp_valid", 32'(rsp_valid_o), 32'd1);
      checkOutput("hold_rsp_rdata", rsp_rdata_o, e_rdata);
      checkOutput("hold_rsp_err", 32'(rsp_err_o), 32'(e_err));
      checkOutput("hold_timeout_low", 32'(timeout_o), 32'd0);
      checkOutput("hold_req_ready", 32'(req_ready_o), 32'd0);
    end
    rsp_ready_i = 1'b1;
    @(negedge clk_i);
    rsp_ready_i = 1'b0;
    checkOutput("done_rsp_valid", 32'(rsp_valid_o), 32'd0);
    checkOutput("done_req_ready", 32'(req_ready_o), 32'd1);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog simulation time exceeded");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    rst_i       = 1'b1;
    req_valid_i = 1'b0;
    req_addr_i  = '0;
    req_we_i    = 1'b0;
    req_wdata_i = '0;
    rsp_ready_i = 1'b0;
    PREADY      = 1'b0;
    PSLVERR     = 1'b0;
    PRDATA      = '0;
    repeat (3) @(negedge clk_i);
    checkOutput("rst_psel", 32'(PSEL), 32'd0);
    checkOutput("rst_penable", 32'(PENABLE), 32'd0);
    checkOutput("rst_rsp_valid", 32'(rsp_valid_o), 32'd0);
    checkOutput("rst_req_ready", 32'(req_ready_o), 32'd1);
    checkOutput("rst_paddr", 32'(PADDR), 32'd0);
    checkOutput("rst_rdata", rsp_rdata_o, 32'd0);
    rst_i = 1'b0;
    @(negedge clk_i);

    applyStimulus(12'h004, 1'b1, 32'hFFFF_0000, 0, 1'b0, 32'h1234_5678, 0);
    applyStimulus(12'h008, 1'b0, 32'h0BAD_0BAD, 3, 1'b0, 32'hDEAD_BEEF, 0);
    applyStimulus(12'h00C, 1'b0, 32'h0000_0000, 0, 1'b1, 32'hCAFE_F00D, 0);
    applyStimulus(12'h010, 1'b0, 32'h0000_0000, 0, 1'b0, 32'h5555_AAAA, 0);
    applyStimulus(12'h014, 1'b0, 32'h0000_0000, 6, 1'b0, 32'h7777_7777, 1);
    applyStimulus(12'h018, 1'b1, 32'h1357_9BDF, 3, 1'b1, 32'h8888_8888, 0);
    applyStimulus(12'h01C, 1'b0, 32'h0000_0000, 2, 1'b0, 32'hA5A5_5A5A, 5);

    // Reset while the slave is stalling in ACCESS.
    slv_wait    = 10;
    req_valid_i = 1'b1;
    req_addr_i  = 12'h020;
    req_we_i    = 1'b1;
    req_wdata_i = 32'h2468_ACE0;
    @(negedge clk_i);
    req_valid_i = 1'b0;
    @(negedge clk_i);
    checkOutput("pre_rst_penable", 32'(PENABLE), 32'd1);
    rst_i = 1'b1;
    @(negedge clk_i);
    checkOutput("midrst_psel", 32'(PSEL), 32'd0);
    checkOutput("midrst_penable", 32'(PENABLE), 32'd0);
    checkOutput("midrst_rsp_valid", 32'(rsp_valid_o), 32'd0);
    checkOutput("midrst_req_ready", 32'(req_ready_o), 32'd1);
    checkOutput("midrst_paddr", 32'(PADDR), 32'd0);
    rst_i = 1'b0;
    @(negedge clk_i);

    for (int n = 0; n < 40; n++) begin
      applyStimulus(AW'($urandom), 1'($urandom_range(0, 1)), $urandom,
                    $urandom_range(0, 6), 1'($urandom_range(0, 1)), $urandom,
                    $urandom_range(0, 3));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
